// File: rtl/divctl_pkg.sv
// divctl_pkg: shared state encoding and widths for the clock-divide controller.
package divctl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} divctl_state_t;
  localparam int TICKCNT_W = 16;
endpackage

// File: rtl/divctl_core.sv
// divctl_core: divide counter with registered clk_out/tick derived from the next count.
module divctl_core #(
  parameter int W = 11
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic [W-1:0] div_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic         clk_out_o,
  output logic         tick_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d, tick_q, tick_d;
  // tick_q marks the last count of the period, so it doubles as the wrap condition
  always_comb begin
    cnt_d  = clr_i ? '0 : en_i ? (tick_q ? '0 : cnt_q + W'(1)) : cnt_q;
    clk_d  = !clr_i && (cnt_d >= (div_i >> 1));
    tick_d = !clr_i && (cnt_d == div_i - W'(1));
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
endmodule

// File: rtl/divctl.sv
// divctl: runtime-programmable clock divider; ratio changes land only on period boundaries.
// Optional tick counter output enabled by DIVCTL_TICKCNT_EN.
module divctl
  import divctl_pkg::*;
#(
  parameter int MAX_DIV = 1024,
  parameter int DEF_DIV = 2,
  localparam int W = $clog2(MAX_DIV + 1)
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 cfg_valid,
  input  logic [W-1:0]         cfg_div,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic                 clk_out,
  output logic                 tick,
`ifdef DIVCTL_TICKCNT_EN
  output logic [TICKCNT_W-1:0] tick_cnt,
`endif
  output logic                 busy
);
  divctl_state_t state_q, state_d;
  logic [W-1:0]  div_q, div_d, pend_q, pend_d;
  logic          err_q, xfer, legal;
  assign cfg_ready = state_q != PEND;
  assign busy      = state_q != IDLE;
  assign cfg_err   = err_q;
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = cfg_div != '0 && cfg_div <= W'(MAX_DIV);
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (xfer && legal) div_d = cfg_div;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (xfer && legal) begin
          pend_d  = cfg_div;
          state_d = PEND;
        end
        if (tick && !run) state_d = IDLE;
      end
      PEND: begin
        if (tick) begin
          div_d   = pend_q;
          state_d = run ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= W'(DEF_DIV);
      pend_q  <= W'(DEF_DIV);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      err_q   <= xfer && !legal;
    end
  end
  // the core sees the next ratio so outputs match the period they start
  divctl_core #(.W(W)) u_core (
    .clk_in   (clk_in),
    .reset    (reset),
    .div_i    (div_d),
    .en_i     (state_q != IDLE),
    .clr_i    (state_d == IDLE),
    .clk_out_o(clk_out),
    .tick_o   (tick)
  );
`ifdef DIVCTL_TICKCNT_EN
  logic [TICKCNT_W-1:0] tcnt_q;
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) tcnt_q <= '0;
    else if (tick) tcnt_q <= tcnt_q + TICKCNT_W'(1);
  end
  assign tick_cnt = tcnt_q;
`endif
endmodule

// File: doc/divctl.md
# divctl

Runtime-programmable clock-divide controller. It owns one divide counter and produces a divided clock `clk_out` plus a one-cycle `tick` strobe per period. It accepts new divide ratios over a valid/ready handshake and applies them only at period boundaries, so `clk_out` never glitches or produces a short phase. It sits between the system control logic and every consumer of slow clocks or enables, and replaces fixed-ratio dividers wherever the rate must change at run time.

## Interface
- `MAX_DIV`, 1024: largest legal divide ratio; `W = $clog2(MAX_DIV+1)`.
- `DEF_DIV`, 2: divide ratio loaded at reset; must satisfy 1 ≤ DEF_DIV ≤ MAX_DIV.
- `clk_in` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: level; 1 = divider runs, 0 = stop at the next period boundary.
- `cfg_valid` in 1: a new ratio is offered.
- `cfg_div` in W: offered ratio.
- `cfg_ready` out 1: controller can accept a ratio.
- `cfg_err` out 1: one-cycle pulse; the accepted ratio was illegal and has been discarded.
- `clk_out` out 1: divided clock, registered.
- `tick` out 1: one-cycle pulse in the last cycle of each period, registered.
- `busy` out 1: state ≠ IDLE.
- `tick_cnt` out 16: present only with `DIVCTL_TICKCNT_EN`.

## Operation
- **Reset values:**
  - state = IDLE, counter = 0, `div_reg` = `pend_reg` = DEF_DIV.
  - `clk_out` = 0, `tick` = 0, `cfg_ready` = 1, `cfg_err` = 0, `busy` = 0, `tick_cnt` = 0.
- **Handshake:** a transfer occurs on any edge where `cfg_valid` & `cfg_ready`.
  - A legal value satisfies 1 ≤ `cfg_div` ≤ MAX_DIV.
  - An illegal value (0 or > MAX_DIV) completes the handshake, pulses `cfg_err` on the next cycle and changes nothing else.
- **IDLE:**
  - Counter is held at 0, `clk_out` = 0, `cfg_ready` = 1.
  - A legal transfer writes `div_reg` directly.
  - `run` = 1 moves the block to RUN, with the counter at 0 in the first RUN cycle.
- **RUN:**
  - Counter increments each cycle and wraps from `div_reg`−1 to 0.
  - `cfg_ready` = 1. A legal transfer writes `pend_reg` and moves the block to PEND.
- **PEND:**
  - Counts exactly as RUN. `cfg_ready` = 0.
  - At the wrap edge: `div_reg` ← `pend_reg`, then return to RUN.
- **Stop:** if `run` = 0 at a wrap edge in RUN or PEND, the block goes to IDLE. A pending ratio is applied first.
- **Output functions:**
  - `clk_out` = 1 iff counter ≥ `div_reg`>>1.
  - `tick` = 1 iff counter = `div_reg`−1.
  - Both are registered from the next-counter value, so they align with the counter cycle they describe.
  - `div_reg` = 1: `clk_out` is held at 1 and `tick` is high every cycle.
- **Simultaneous transfer and wrap in RUN:** the new value goes to `pend_reg` and is applied at the *following* wrap, not the current one.
- **`run` drops in PEND:** the pending value is applied and the block then goes to IDLE.
- **Reset mid-operation:** everything returns immediately to the reset values; any pending ratio is lost.

## Timing
- Period is exactly `div_reg` cycles.
- `clk_out` is low for floor(div/2) cycles, then high for ceil(div/2) cycles.
- `run` sampled high in IDLE at edge 0: counter = 0 in cycle 1; first `tick` in cycle `div_reg`.
- Configuration latency:
  - IDLE: `div_reg` is updated 1 cycle after the transfer.
  - RUN/PEND: the new ratio takes effect at the first period starting after the next wrap.
- `cfg_err` appears exactly 1 cycle after the transfer.

## Configuration
- `DIVCTL_TICKCNT_EN` defined:
  - Port `tick_cnt` (16 bits) exists.
  - It increments on every cycle with `tick` = 1 and wraps 0xFFFF→0.
  - It resets to 0 and holds its value in IDLE.
- Macro undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package `divctl_pkg`:
  - state enum `divctl_state_t` {IDLE, RUN, PEND};
  - constant `TICKCNT_W` = 16.
- Sub-module `divctl_core`:
  - Contains the counter plus the `clk_out`/`tick` generation.
  - Inputs: `div_reg`, count enable, synchronous clear.
  - The FSM and handshake stay in `divctl`.

## Test plan
- Reset, `cfg_div` = 4 in IDLE, `run` = 1 → `clk_out` sequence 0,0,1,1 repeating; `tick` on every 4th cycle; `busy` = 1.
- RUN at div 4, transfer `cfg_div` = 5 mid-period → `cfg_ready` drops; current period stays 4 cycles; subsequent periods are 5 cycles (low 2 / high 3).
- Transfer `cfg_div` = 0, then MAX_DIV+1 → `cfg_err` pulses 1 cycle after each; period unchanged; state unchanged.
- `div_reg` = 1 → `clk_out` constantly 1, `tick` constantly 1; transfer 3 applied after one cycle.
- `run` dropped at counter 1 of div 6 → period completes; IDLE after the wrap with `clk_out` = 0, `busy` = 0; with `DIVCTL_TICKCNT_EN`, `tick_cnt` is frozen.
- Assert `reset` while in PEND → all outputs at reset values asynchronously; after release, period = DEF_DIV.
